stack_cpu_control: RTL and testbench
====================================

Name: stack_cpu_control

Overview:
- Control sequencer for the stack-processor datapath.
- Fetches from PC, decodes the 6-bit opcode, then issues per-cycle register-write enables, mux selects, ALU function and memory write for each instruction phase.
- Sits directly upstream of the datapath and drives all of its control inputs.
- Reports stack faults and illegal opcodes through a sticky error.

Parameters:
- STACK_TOP, 16'hFFFF, stack start point; SR equal to this means the stack is empty.
- STACK_LIMIT, 16'h0040, lowest legal SR; a push that would go below it is overflow.
- ALU_PASS, 4'hF, ALU function code that passes R1 through to ALU_res.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- opcode  in  6  cmd register bits [15:10]
- sr_value  in  16  current SR_out
- cmd_w  out  1  load cmd register from in_data
- R1_w  out  1  load R1 from in_data
- R2_w  out  1  load R2 from in_data
- SR_w  out  1  load SR
- PC_w  out  1  load PC
- SR_inc  out  1  SR incdec direction: 1 = +1, 0 = -1
- PC_inc  out  1  PC incdec direction: 1 = +1, 0 = -1
- SR_incc  out  2  SR input mux: 0 ALU_res, 1 incdec, 2 start point, 3 zero
- PC_incc  out  2  PC input mux: 0 ALU_res, 1 incdec, 2 entry point, 3 zero
- ALU_func  out  4  ALU operation
- addr_sel  out  2  address mux: 0 SR_out, 1 SR_id, 2 PC_out, 3 R1
- data_sel  out  2  write-data mux: 0 SR_out, 1 PC_id, 2 ALU_res, 3 cmd_o
- write_memory  out  1  memory write strobe
- error  out  1  sticky fault flag
- halted  out  1  HALT executed

Behaviour:
- The clock is clk. There is one clock domain. Reset rst is synchronous and active-high.
- Memory read latency is 1 cycle: address presented in cycle N, in_data is captured in cycle N+1.
- The stack grows downward. SR points at the top element. Push writes to SR-1 and then sets SR to SR-1. Pop reads at SR and then sets SR to SR+1.
- Defaults in every state: all write enables 0, write_memory 0, addr_sel 2, data_sel 0, SR_incc/PC_incc 1, SR_inc/PC_inc 1, ALU_func 0.
- Reset:
  - While rst is high, state is INIT, error is 0 and halted is 0.
  - INIT lasts 1 cycle: SR_w=1, SR_incc=2, PC_w=1, PC_incc=2. The datapath registers have no reset, so this loads the start and entry points. Next state is FETCH.
  - rst asserted in any state, including mid-instruction, returns the controller to INIT on the next edge. No write_memory is issued in the cycle after rst rises.
- Fetch:
  - FETCH: addr_sel=2. Next state is FETCH_W.
  - FETCH_W: cmd_w=1, PC_w=1, PC_incc=1, PC_inc=1. Next state is DECODE.
- DECODE routes on opcode:
  - 6'h00 NOP: to FETCH.
  - 6'h01 PUSHI: to PUSH_IMM.
  - 6'h10-6'h1E binary ALU op: to POP1, with op class BIN.
  - 6'h20 JMP: to POP1, with op class JMP.
  - 6'h3F HALT: to HALT.
  - Any other opcode: to ERROR.
- POP1 / POP1_W:
  - If sr_value==STACK_TOP, go to ERROR (underflow).
  - Otherwise POP1 drives addr_sel=0.
  - POP1_W: R1_w=1, SR_w=1, SR_incc=1, SR_inc=1.
  - After POP1_W, class BIN goes to POP2 and class JMP goes to JMP_X.
- POP2 / POP2_W: same as POP1 / POP1_W with R2_w instead of R1_w, including the same underflow check. Next state is PUSH_ALU.
- Push states:
  - PUSH_ALU: ALU_func=opcode[3:0], addr_sel=1, SR_inc=0, data_sel=2, write_memory=1, SR_w=1, SR_incc=1. Next state is FETCH.
  - PUSH_IMM: same as PUSH_ALU but data_sel=3. Next state is FETCH.
  - Both push states go to ERROR with no write if sr_value-1 < STACK_LIMIT (overflow).
- JMP_X: ALU_func=ALU_PASS, PC_w=1, PC_incc=0. Next state is FETCH.
- HALT: halted=1. The state is absorbing; only rst leaves it.
- ERROR: error=1. The state is absorbing; only rst leaves it. No enables are asserted.
- Latencies:
  - NOP: 3 cycles.
  - PUSHI: 4 cycles.
  - Binary op: 8 cycles.
  - JMP: 6 cycles.
- The opcode input is only sampled in DECODE. The cmd register is stable from FETCH_W onward.

Decomposition:
- Package stack_cpu_pkg holds:
  - Opcode constants: OP_NOP, OP_PUSHI, OP_ALU_BASE, OP_JMP, OP_HALT.
  - State enum: INIT, FETCH, FETCH_W, DECODE, POP1, POP1_W, POP2, POP2_W, PUSH_ALU, PUSH_IMM, JMP_X, HALT, ERROR.
  - Mux-select constants: ADDR_SR, ADDR_SRID, ADDR_PC, ADDR_R1; DATA_SR, DATA_PCID, DATA_ALU, DATA_CMD; NEXT_ALU, NEXT_ID, NEXT_START, NEXT_ZERO.
- Sub-module stack_cpu_decode: combinational opcode to {next state, op class, illegal}, kept separate so the opcode map can be tested on its own.

Test Plan:
- Reset then run 3 cycles with opcode=00 -> INIT asserts SR_w, PC_w with both incc=2. FETCH has addr_sel=2. FETCH_W has cmd_w=1, PC_w=1, PC_inc=1.
- PUSHI with sr_value=FFFF -> in cycle 4: addr_sel=1, SR_inc=0, data_sel=3, write_memory=1, SR_w=1. Back to FETCH in cycle 5.
- opcode=6'h12 with sr_value=FFFD -> R1_w and R2_w each pulse once with SR_inc=1. PUSH_ALU has ALU_func=4'h2, data_sel=2, write_memory=1. Total 8 cycles.
- JMP with sr_value=FFFE -> R1_w pulses, then JMP_X has PC_w=1, PC_incc=0, ALU_func=F. Then FETCH.
- ALU op with sr_value=FFFF -> ERROR, error=1 held for 10 cycles, no write_memory. rst=1 clears error.
- opcode=6'h2A -> ERROR. opcode=6'h3F -> halted=1 and stays; PUSHI at sr_value=0040 -> ERROR (overflow).

Source files
------------

// File: rtl/stack_cpu_pkg.sv
// Shared opcode map, controller state encoding and datapath mux-select codes
// for the stack-processor control sequencer.
package stack_cpu_pkg;

   localparam logic [5:0] OP_NOP      = 6'h00;
   localparam logic [5:0] OP_PUSHI    = 6'h01;
   localparam logic [5:0] OP_ALU_BASE = 6'h10;
   localparam logic [5:0] OP_ALU_LAST = 6'h1E;
   localparam logic [5:0] OP_JMP      = 6'h20;
   localparam logic [5:0] OP_HALT     = 6'h3F;

   typedef enum logic [3:0] {
      INIT,
      FETCH,
      FETCH_W,
      DECODE,
      POP1,
      POP1_W,
      POP2,
      POP2_W,
      PUSH_ALU,
      PUSH_IMM,
      JMP_X,
      HALT,
      ERROR
   } state_t;

   typedef enum logic {
      CLS_BIN,
      CLS_JMP
   } op_class_t;

   localparam logic [1:0] ADDR_SR    = 2'd0;
   localparam logic [1:0] ADDR_SRID  = 2'd1;
   localparam logic [1:0] ADDR_PC    = 2'd2;
   localparam logic [1:0] ADDR_R1    = 2'd3;

   localparam logic [1:0] DATA_SR    = 2'd0;
   localparam logic [1:0] DATA_PCID  = 2'd1;
   localparam logic [1:0] DATA_ALU   = 2'd2;
   localparam logic [1:0] DATA_CMD   = 2'd3;

   localparam logic [1:0] NEXT_ALU   = 2'd0;
   localparam logic [1:0] NEXT_ID    = 2'd1;
   localparam logic [1:0] NEXT_START = 2'd2;
   localparam logic [1:0] NEXT_ZERO  = 2'd3;

endpackage

// File: rtl/stack_cpu_decode.sv
// Combinational opcode decoder: maps the 6-bit opcode to the state that
// follows DECODE, the operand-pop class, and an illegal-opcode flag.
module stack_cpu_decode
   import stack_cpu_pkg::*;
(
   input  logic [5:0] opcode,
   output state_t     next_state,
   output op_class_t  op_class,
   output logic       illegal
);

   always_comb begin
      next_state = ERROR;
      op_class   = CLS_BIN;
      illegal    = 1'b0;
      if (opcode == OP_NOP) begin
         next_state = FETCH;
      end else if (opcode == OP_PUSHI) begin
         next_state = PUSH_IMM;
      end else if (opcode >= OP_ALU_BASE && opcode <= OP_ALU_LAST) begin
         next_state = POP1;
         op_class   = CLS_BIN;
      end else if (opcode == OP_JMP) begin
         next_state = POP1;
         op_class   = CLS_JMP;
      end else if (opcode == OP_HALT) begin
         next_state = HALT;
      end else begin
         illegal    = 1'b1;
      end
   end

endmodule

// File: rtl/stack_cpu_control.sv
// Control sequencer for the stack-processor datapath: fetch, decode and
// per-phase control strobes, with sticky error and halt flags.
module stack_cpu_control
   import stack_cpu_pkg::*;
#(
   parameter logic [15:0] STACK_TOP   = 16'hFFFF,
   parameter logic [15:0] STACK_LIMIT = 16'h0040,
   parameter logic [3:0]  ALU_PASS    = 4'hF
)
(
   input  logic        clk,
   input  logic        rst,
   input  logic [5:0]  opcode,
   input  logic [15:0] sr_value,
   output logic        cmd_w,
   output logic        R1_w,
   output logic        R2_w,
   output logic        SR_w,
   output logic        PC_w,
   output logic        SR_inc,
   output logic        PC_inc,
   output logic [1:0]  SR_incc,
   output logic [1:0]  PC_incc,
   output logic [3:0]  ALU_func,
   output logic [1:0]  addr_sel,
   output logic [1:0]  data_sel,
   output logic        write_memory,
   output logic        error,
   output logic        halted
);

   state_t    state;
   state_t    nxt;
   state_t    dec_next;
   op_class_t dec_class;
   op_class_t op_class;
   logic      dec_illegal;
   logic [3:0] alu_op;
   logic      underflow;
   logic      overflow;

   stack_cpu_decode u_decode (
      .opcode     (opcode),
      .next_state (dec_next),
      .op_class   (dec_class),
      .illegal    (dec_illegal)
   );

   assign underflow = (sr_value == STACK_TOP);
   // sr_value-1 < STACK_LIMIT, written so SR=0 does not wrap to a legal value
   assign overflow  = (sr_value <= STACK_LIMIT);

   always_comb begin
      nxt = ERROR;
      case (state)
         INIT:     nxt = FETCH;
         FETCH:    nxt = FETCH_W;
         FETCH_W:  nxt = DECODE;
         DECODE:   nxt = dec_illegal ? ERROR : dec_next;
         POP1:     nxt = underflow ? ERROR : POP1_W;
         POP1_W:   nxt = (op_class == CLS_JMP) ? JMP_X : POP2;
         POP2:     nxt = underflow ? ERROR : POP2_W;
         POP2_W:   nxt = PUSH_ALU;
         PUSH_ALU: nxt = overflow ? ERROR : FETCH;
         PUSH_IMM: nxt = overflow ? ERROR : FETCH;
         JMP_X:    nxt = FETCH;
         HALT:     nxt = HALT;
         ERROR:    nxt = ERROR;
         default:  nxt = ERROR;
      endcase
   end

   // error/halted are registered copies of "next state is ERROR/HALT", so they
   // track the state exactly and clear on the reset edge
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= INIT;
         error    <= 1'b0;
         halted   <= 1'b0;
         op_class <= CLS_BIN;
         alu_op   <= '0;
      end else begin
         state  <= nxt;
         error  <= (nxt == ERROR);
         halted <= (nxt == HALT);
         if (state == DECODE) begin
            op_class <= dec_class;
            alu_op   <= opcode[3:0];
         end
      end
   end

   always_comb begin
      cmd_w        = 1'b0;
      R1_w         = 1'b0;
      R2_w         = 1'b0;
      SR_w         = 1'b0;
      PC_w         = 1'b0;
      SR_inc       = 1'b1;
      PC_inc       = 1'b1;
      SR_incc      = NEXT_ID;
      PC_incc      = NEXT_ID;
      ALU_func     = '0;
      addr_sel     = ADDR_PC;
      data_sel     = DATA_SR;
      write_memory = 1'b0;
      case (state)
         INIT: begin
            SR_w    = 1'b1;
            SR_incc = NEXT_START;
            PC_w    = 1'b1;
            PC_incc = NEXT_START;
         end
         FETCH: addr_sel = ADDR_PC;
         FETCH_W: begin
            cmd_w   = 1'b1;
            PC_w    = 1'b1;
            PC_incc = NEXT_ID;
            PC_inc  = 1'b1;
         end
         POP1, POP2: begin
            if (!underflow) addr_sel = ADDR_SR;
         end
         POP1_W, POP2_W: begin
            R1_w    = (state == POP1_W);
            R2_w    = (state == POP2_W);
            SR_w    = 1'b1;
            SR_incc = NEXT_ID;
            SR_inc  = 1'b1;
         end
         PUSH_ALU, PUSH_IMM: begin
            if (!overflow) begin
               ALU_func     = alu_op;
               addr_sel     = ADDR_SRID;
               SR_inc       = 1'b0;
               data_sel     = (state == PUSH_IMM) ? DATA_CMD : DATA_ALU;
               write_memory = 1'b1;
               SR_w         = 1'b1;
               SR_incc      = NEXT_ID;
            end
         end
         JMP_X: begin
            ALU_func = ALU_PASS;
            PC_w     = 1'b1;
            PC_incc  = NEXT_ALU;
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_stack_cpu_control.sv
// Directed, table-driven check of the stack-CPU control sequencer: one row per
// clock cycle of inputs and the full expected control-output word.
module tb_stack_cpu_control;

   typedef struct packed {
      logic       cmd_w, r1_w, r2_w, sr_w, pc_w, sr_inc, pc_inc;
      logic [1:0] sr_incc, pc_incc;
      logic [3:0] alu_func;
      logic [1:0] addr_sel, data_sel;
      logic       write_memory, error, halted;
   } ctl_t;

   typedef struct {
      logic        rst;
      logic [5:0]  op;
      logic [15:0] sr;
      ctl_t        exp;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst;
   logic [5:0]  opcode;
   logic [15:0] sr_value;
   logic        cmd_w, R1_w, R2_w, SR_w, PC_w, SR_inc, PC_inc;
   logic [1:0]  SR_incc, PC_incc, addr_sel, data_sel;
   logic [3:0]  ALU_func;
   logic        write_memory, error, halted;

   int unsigned errors = 0;
   int unsigned checks = 0;
   vec_t        tbl[$];

   always #5 clk = ~clk;

   stack_cpu_control #(
      .STACK_TOP   (16'hFFFF),
      .STACK_LIMIT (16'h0040),
      .ALU_PASS    (4'hF)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .opcode       (opcode),
      .sr_value     (sr_value),
      .cmd_w        (cmd_w),
      .R1_w         (R1_w),
      .R2_w         (R2_w),
      .SR_w         (SR_w),
      .PC_w         (PC_w),
      .SR_inc       (SR_inc),
      .PC_inc       (PC_inc),
      .SR_incc      (SR_incc),
      .PC_incc      (PC_incc),
      .ALU_func     (ALU_func),
      .addr_sel     (addr_sel),
      .data_sel     (data_sel),
      .write_memory (write_memory),
      .error        (error),
      .halted       (halted)
   );

   function automatic ctl_t e_idle();
      ctl_t c = '0;
      c.sr_incc = 2'd1; c.pc_incc = 2'd1;
      c.sr_inc  = 1'b1; c.pc_inc  = 1'b1;
      c.addr_sel = 2'd2;
      return c;
   endfunction

   function automatic ctl_t e_init();
      ctl_t c = e_idle();
      c.sr_w = 1'b1; c.sr_incc = 2'd2; c.pc_w = 1'b1; c.pc_incc = 2'd2;
      return c;
   endfunction

   function automatic ctl_t e_fetchw();
      ctl_t c = e_idle();
      c.cmd_w = 1'b1; c.pc_w = 1'b1;
      return c;
   endfunction

   function automatic ctl_t e_pop();
      ctl_t c = e_idle();
      c.addr_sel = 2'd0;
      return c;
   endfunction

   function automatic ctl_t e_popw(input bit second);
      ctl_t c = e_idle();
      c.r1_w = !second; c.r2_w = second; c.sr_w = 1'b1;
      return c;
   endfunction

   function automatic ctl_t e_push(input logic [3:0] func, input logic [1:0] dsel);
      ctl_t c = e_idle();
      c.alu_func = func; c.addr_sel = 2'd1; c.sr_inc = 1'b0;
      c.data_sel = dsel; c.write_memory = 1'b1; c.sr_w = 1'b1;
      return c;
   endfunction

   function automatic ctl_t e_jmp();
      ctl_t c = e_idle();
      c.alu_func = 4'hF; c.pc_w = 1'b1; c.pc_incc = 2'd0;
      return c;
   endfunction

   function automatic ctl_t e_err();
      ctl_t c = e_idle();
      c.error = 1'b1;
      return c;
   endfunction

   function automatic ctl_t e_halt();
      ctl_t c = e_idle();
      c.halted = 1'b1;
      return c;
   endfunction

   task automatic add(input logic r, input logic [5:0] op, input logic [15:0] sr, input ctl_t e);
      vec_t v;
      v.rst = r; v.op = op; v.sr = sr; v.exp = e;
      tbl.push_back(v);
   endtask

   // fetch, fetch-wait and decode of one instruction
   task automatic add_fetch(input logic [5:0] op, input logic [15:0] sr);
      add(0, op, sr, e_idle());
      add(0, op, sr, e_fetchw());
      add(0, op, sr, e_idle());
   endtask

   task automatic step(input logic r, input logic [5:0] op, input logic [15:0] sr,
                       input ctl_t e, input string name);
      ctl_t act;
      @(negedge clk);
      rst = r; opcode = op; sr_value = sr;
      #1;
      act = {cmd_w, R1_w, R2_w, SR_w, PC_w, SR_inc, PC_inc, SR_incc, PC_incc,
             ALU_func, addr_sel, data_sel, write_memory, error, halted};
      checks++;
      if (act !== e) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, e);
      end
   endtask

   initial begin
      rst = 1'b1; opcode = '0; sr_value = 16'hFFFF;
      @(posedge clk);

      add(1, 6'h00, 16'hFFFF, e_init());
      add(0, 6'h00, 16'hFFFF, e_init());
      add_fetch(6'h00, 16'hFFFF);                    // NOP
      add_fetch(6'h01, 16'hFFFF);                    // PUSHI, empty stack
      add(0, 6'h01, 16'hFFFF, e_push(4'h1, 2'd3));
      add_fetch(6'h12, 16'hFFFD);                    // binary op
      add(0, 6'h12, 16'hFFFD, e_pop());
      add(0, 6'h12, 16'hFFFD, e_popw(0));
      add(0, 6'h12, 16'hFFFD, e_pop());
      add(0, 6'h12, 16'hFFFD, e_popw(1));
      add(0, 6'h12, 16'hFFFD, e_push(4'h2, 2'd2));
      add_fetch(6'h20, 16'hFFFE);                    // JMP
      add(0, 6'h20, 16'hFFFE, e_pop());
      add(0, 6'h20, 16'hFFFE, e_popw(0));
      add(0, 6'h20, 16'hFFFE, e_jmp());
      add_fetch(6'h13, 16'hFFFF);                    // underflow
      add(0, 6'h13, 16'hFFFF, e_idle());
      for (int i = 0; i < 10; i++) add(0, 6'h13, 16'hFFFF, e_err());
      add(1, 6'h13, 16'hFFFF, e_err());
      add(0, 6'h2A, 16'hFFFF, e_init());
      add_fetch(6'h2A, 16'hFFFF);                    // illegal opcode
      add(0, 6'h2A, 16'hFFFF, e_err());
      add(1, 6'h2A, 16'hFFFF, e_err());
      add(0, 6'h3F, 16'hFFFF, e_init());
      add_fetch(6'h3F, 16'hFFFF);                    // HALT
      add(0, 6'h3F, 16'hFFFF, e_halt());
      add(0, 6'h00, 16'hFFFF, e_halt());
      add(1, 6'h00, 16'hFFFF, e_halt());
      add(0, 6'h01, 16'h0040, e_init());
      add_fetch(6'h01, 16'h0040);                    // overflow at the limit
      add(0, 6'h01, 16'h0040, e_idle());
      add(0, 6'h01, 16'h0040, e_err());
      add(1, 6'h01, 16'h0041, e_err());
      add(0, 6'h01, 16'h0041, e_init());
      add_fetch(6'h01, 16'h0041);                    // one above the limit
      add(0, 6'h01, 16'h0041, e_push(4'h1, 2'd3));
      add_fetch(6'h1F, 16'hFFF0);                    // just past the ALU range
      add(0, 6'h1F, 16'hFFF0, e_err());

      for (int i = 0; i < tbl.size(); i++)
         step(tbl[i].rst, tbl[i].op, tbl[i].sr, tbl[i].exp, $sformatf("row%0d", i));

      // rst mid-instruction: no write in the following cycle, back to INIT
      step(1, 6'h00, 16'hFFFD, e_err(),      "seq_rst_a");
      step(0, 6'h14, 16'hFFFD, e_init(),     "seq_rst_b");
      step(0, 6'h14, 16'hFFFD, e_idle(),     "seq_rst_fetch");
      step(0, 6'h14, 16'hFFFD, e_fetchw(),   "seq_rst_fetchw");
      step(0, 6'h14, 16'hFFFD, e_idle(),     "seq_rst_decode");
      step(0, 6'h14, 16'hFFFD, e_pop(),      "seq_rst_pop1");
      step(0, 6'h14, 16'hFFFD, e_popw(0),    "seq_rst_pop1w");
      step(1, 6'h14, 16'hFFFD, e_pop(),      "seq_rst_pop2");
      step(0, 6'h14, 16'hFFFD, e_init(),     "seq_rst_init");

      // opcode is only sampled in DECODE
      step(0, 6'h15, 16'hFFFD, e_idle(),     "seq_lat_fetch");
      step(0, 6'h15, 16'hFFFD, e_fetchw(),   "seq_lat_fetchw");
      step(0, 6'h15, 16'hFFFD, e_idle(),     "seq_lat_decode");
      step(0, 6'h3F, 16'hFFFD, e_pop(),      "seq_lat_pop1");
      step(0, 6'h2A, 16'hFFFD, e_popw(0),    "seq_lat_pop1w");
      step(0, 6'h20, 16'hFFFD, e_pop(),      "seq_lat_pop2");
      step(0, 6'h3F, 16'hFFFD, e_popw(1),    "seq_lat_pop2w");
      step(0, 6'h3F, 16'hFFFD, e_push(4'h5, 2'd2), "seq_lat_push");
      step(0, 6'h3F, 16'hFFFD, e_idle(),     "seq_lat_fetch2");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: got no finish expected finish");
      $fatal(1, "timeout");
   end

endmodule
